// File: rtl/pool2x2_scheduler_pkg.sv
// Shared types, widths and width helpers for the 2x2 average-pooling scheduler.
package pool_pkg;

  localparam int POOL_DATA_W = 16;
  localparam int POOL_OUT_W  = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_F0    = 3'd1,
    ST_F1    = 3'd2,
    ST_F2    = 3'd3,
    ST_F3    = 3'd4,
    ST_DRAIN = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } pool_state_t;

  // Input buffer address width for an n x n map.
  function automatic int calc_addr_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Output buffer address width for the (n/2) x (n/2) pooled map, at least 1.
  function automatic int calc_out_addr_w(input int n);
    int m;
    m = n / 2;
    return (m * m > 1) ? $clog2(m * m) : 1;
  endfunction

endpackage

// File: rtl/pool2x2_scheduler_if.sv
// Buffer-side bus of the pooling scheduler: input-map reads and pooled-map writes.
interface pool2x2_scheduler_if
  import pool_pkg::*;
#(
  parameter int N      = 28,
  parameter int DATA_W = POOL_DATA_W,
  parameter int OUT_W  = POOL_OUT_W
);
  localparam int ADDR_W     = calc_addr_w(N);
  localparam int OUT_ADDR_W = calc_out_addr_w(N);

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic                     wr_ready;
  logic [OUT_ADDR_W-1:0]    wr_addr;
  logic [OUT_W-1:0]         wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, wr_ready
  );
endinterface

// File: rtl/pool2x2_scheduler_avg.sv
// Combinational 2x2 average: signed four-way sum, floor divide by 4, truncate.
module pool_avg_2x2
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int OUT_W  = POOL_OUT_W
)(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic        [OUT_W-1:0]  avg
);
  localparam int SUM_W = DATA_W + 2;

  logic signed [SUM_W-1:0] sum;

  // Arithmetic shift floors toward minus infinity; no saturation, high bits drop.
  function automatic logic [OUT_W-1:0] floor_div4_trunc(input logic signed [SUM_W-1:0] s);
    return OUT_W'(s >>> 2);
  endfunction

  // Sum at two extra bits so four full-scale pixels never overflow.
  always_comb begin
    sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
    avg = floor_div4_trunc(sum);
  end
endmodule

// File: rtl/pool2x2_scheduler.sv
// Stride-2 window sequencer: fetches four pixels per window, pools them and
// writes the result row-major into the output buffer.
module pool2x2_scheduler
  import pool_pkg::*;
#(
  parameter int N      = 28,
  parameter int DATA_W = POOL_DATA_W,
  parameter int OUT_W  = POOL_OUT_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  pool2x2_scheduler_if.master  bus
);
  localparam int M          = N / 2;
  localparam int ADDR_W     = calc_addr_w(N);
  localparam int OUT_ADDR_W = calc_out_addr_w(N);
  localparam int CNT_W      = (M > 1) ? $clog2(M) : 1;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(M - 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_F0    = ST_F0;
  localparam logic [2:0] S_F1    = ST_F1;
  localparam logic [2:0] S_F2    = ST_F2;
  localparam logic [2:0] S_F3    = ST_F3;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_WRITE = ST_WRITE;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]            state_q;
  logic [CNT_W-1:0]      r_q, c_q, c_nxt;
  logic [ADDR_W-1:0]     row_base_q, rd_addr_q, col_off_nxt;
  logic [OUT_ADDR_W-1:0] wr_addr_q;
  logic                  last_win;

  logic signed [DATA_W-1:0] pix0_p0, pix1_p0, pix2_p0, pix3_p0, pix3_in;
  logic [OUT_W-1:0]         pool_p0;
  logic [OUT_W-1:0]         wr_data_p1;

  assign c_nxt       = c_q + CNT_W'(1);
  assign col_off_nxt = ADDR_W'({c_nxt, 1'b0});
  assign last_win    = (r_q == C_LAST) && (c_q == C_LAST);

  // The fourth pixel arrives during DRAIN, so the pool sees it directly then.
  assign pix3_in = (state_q == S_DRAIN) ? bus.rd_data : pix3_p0;

  pool_avg_2x2 #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_avg (
    .a   (pix0_p0),
    .b   (pix1_p0),
    .c   (pix2_p0),
    .d   (pix3_in),
    .avg (pool_p0)
  );

  // FSM, window counters and registered read/write addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_p1 <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_F0;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
          end
        end
        S_F0: begin
          state_q   <= S_F1;
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        S_F1: begin
          state_q   <= S_F2;
          rd_addr_q <= rd_addr_q + ADDR_W'(N - 1);
        end
        S_F2: begin
          state_q   <= S_F3;
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        S_F3:    state_q <= S_DRAIN;
        S_DRAIN: begin
          state_q    <= S_WRITE;
          wr_data_p1 <= pool_p0;
        end
        S_WRITE: begin
          if (bus.wr_ready) begin
            if (last_win) begin
              state_q    <= S_DONE;
              r_q        <= '0;
              c_q        <= '0;
              row_base_q <= '0;
              rd_addr_q  <= '0;
              wr_addr_q  <= '0;
            end else begin
              state_q   <= S_F0;
              wr_addr_q <= wr_addr_q + OUT_ADDR_W'(1);
              if (c_q == C_LAST) begin
                c_q        <= '0;
                r_q        <= r_q + CNT_W'(1);
                row_base_q <= row_base_q + ADDR_W'(2 * N);
                rd_addr_q  <= row_base_q + ADDR_W'(2 * N);
              end else begin
                c_q       <= c_nxt;
                rd_addr_q <= row_base_q + col_off_nxt;
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---- stage p0: capture each pixel the cycle after its read ----
  always_ff @(posedge clk) begin
    case (state_q)
      S_F1:    pix0_p0 <= bus.rd_data;
      S_F2:    pix1_p0 <= bus.rd_data;
      S_F3:    pix2_p0 <= bus.rd_data;
      S_DRAIN: pix3_p0 <= bus.rd_data;
      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign bus.rd_en   = (state_q == S_F0) || (state_q == S_F1) ||
                       (state_q == S_F2) || (state_q == S_F3);
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = (state_q == S_WRITE);
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_p1;
endmodule

// File: tb/tb_pool2x2_scheduler.sv
// Directed bench for pool2x2_scheduler: N=4 table-driven passes plus reset,
// and an N=5 pass for the odd-edge case.
module tb_pool2x2_scheduler;
  import pool_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, busy_a, done_a;
  logic start_b, busy_b, done_b;

  pool2x2_scheduler_if #(.N(4), .DATA_W(16), .OUT_W(14)) bus_a ();
  pool2x2_scheduler_if #(.N(5), .DATA_W(16), .OUT_W(14)) bus_b ();

  pool2x2_scheduler #(.N(4), .DATA_W(16), .OUT_W(14)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_a),
    .busy  (busy_a),
    .done  (done_a),
    .bus   (bus_a)
  );

  pool2x2_scheduler #(.N(5), .DATA_W(16), .OUT_W(14)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_b),
    .busy  (busy_b),
    .done  (done_b),
    .bus   (bus_b)
  );

  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [25];

  // Single-port buffers: data is valid the cycle after the read strobe.
  always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
  always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr];

  typedef struct {
    int          fill;       // 0: ramp row*4+col, 1: negative windows
    int          stall_n;    // wr_ready low cycles on window 1
    int          start_cyc;  // cycle of an extra start pulse, -1 none
    int          exp_done;   // cycle in which done is expected
    logic [13:0] exp_d [4];  // pooled values in write order
  } vec_t;

  vec_t vec [4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int fill, input int sn, input int sc, input int ed,
                         input logic [13:0] d0, input logic [13:0] d1,
                         input logic [13:0] d2, input logic [13:0] d3);
    vec[i].fill      = fill;
    vec[i].stall_n   = sn;
    vec[i].start_cyc = sc;
    vec[i].exp_done  = ed;
    vec[i].exp_d[0]  = d0;
    vec[i].exp_d[1]  = d1;
    vec[i].exp_d[2]  = d2;
    vec[i].exp_d[3]  = d3;
  endtask

  task automatic fill_mem_a(input int mode);
    for (int i = 0; i < 16; i++) mem_a[i] = (mode == 0) ? 16'(i) : 16'sd0;
    if (mode == 1) begin
      mem_a[0] = -16'sd3; mem_a[1] = -16'sd3; mem_a[4] = -16'sd3; mem_a[5] = -16'sd3;
      mem_a[2] = -16'sd1; mem_a[3] = -16'sd1; mem_a[6] = -16'sd1; mem_a[7] = -16'sd2;
    end
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_busy"},    32'(busy_a),        32'd0);
    chk({tag, "_done"},    32'(done_a),        32'd0);
    chk({tag, "_rd_en"},   32'(bus_a.rd_en),   32'd0);
    chk({tag, "_wr_en"},   32'(bus_a.wr_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(bus_a.rd_addr), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus_a.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus_a.wr_data), 32'd0);
  endtask

  // One full N=4 pass from a start pulse; cycle 1 is the first cycle after edge 0.
  task automatic run_a(input int v);
    int          k, dcnt, dcyc, hold, stall_used;
    logic        pend;
    logic [1:0]  pa;
    logic [13:0] pd;
    k = 0; dcnt = 0; dcyc = -1; hold = 0; stall_used = 0; pend = 1'b0; pa = '0; pd = '0;
    fill_mem_a(vec[v].fill);
    @(negedge clk);
    start_a = 1'b1;
    bus_a.wr_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start_a = (cyc == vec[v].start_cyc);
      bus_a.wr_ready = 1'b1;
      if (bus_a.wr_en && k == 1 && stall_used < vec[v].stall_n) begin
        bus_a.wr_ready = 1'b0;
        stall_used++;
      end
      #1;
      if (cyc == 1) begin
        chk($sformatf("v%0d_busy_rise", v), 32'(busy_a), 32'd1);
        chk($sformatf("v%0d_first_rd_addr", v), 32'(bus_a.rd_addr), 32'd0);
      end
      if (bus_a.wr_en) begin
        if (k == 1) hold++;
        if (pend) begin
          chk($sformatf("v%0d_hold_addr", v), 32'(bus_a.wr_addr), 32'(pa));
          chk($sformatf("v%0d_hold_data", v), 32'(bus_a.wr_data), 32'(pd));
        end
        if (bus_a.wr_ready) begin
          if (k < 4) begin
            chk($sformatf("v%0d_wr_addr%0d", v, k), 32'(bus_a.wr_addr), 32'(k));
            chk($sformatf("v%0d_wr_data%0d", v, k), 32'(bus_a.wr_data), 32'(vec[v].exp_d[k]));
          end else begin
            chk($sformatf("v%0d_extra_write", v), 32'(k), 32'd3);
          end
          k++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pa = bus_a.wr_addr;
          pd = bus_a.wr_data;
        end
      end
      if (done_a) begin
        dcnt++;
        dcyc = cyc;
      end
      if (dcnt > 0 && cyc == dcyc + 1)
        chk($sformatf("v%0d_busy_fall", v), 32'(busy_a), 32'd0);
    end
    start_a = 1'b0;
    chk($sformatf("v%0d_writes", v), 32'(k), 32'd4);
    chk($sformatf("v%0d_done_cnt", v), 32'(dcnt), 32'd1);
    chk($sformatf("v%0d_done_cyc", v), 32'(dcyc), 32'(vec[v].exp_done));
    chk($sformatf("v%0d_win1_wr_cycles", v), 32'(hold), 32'(1 + vec[v].stall_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         kb, nrd, dcnt_b, dcyc_b;
    logic [31:0] rd_seen_b;
    int         unread [8];
    logic [13:0] exp_b [4];

    set_vec(0, 0, 0, -1, 25, 14'd2,     14'd4,     14'd10, 14'd12);
    set_vec(1, 1, 0, -1, 25, 14'h3FFD,  14'h3FFE,  14'd0,  14'd0);
    set_vec(2, 0, 3, -1, 28, 14'd2,     14'd4,     14'd10, 14'd12);
    set_vec(3, 0, 0, 10, 25, 14'd2,     14'd4,     14'd10, 14'd12);

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.wr_ready = 1'b1;
    bus_b.wr_ready = 1'b1;
    fill_mem_a(0);
    for (int i = 0; i < 25; i++) mem_b[i] = 16'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_idle_a("reset");
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) run_a(v);

    // Reset in cycle 13 (window 2 fetch) abandons the pass.
    fill_mem_a(0);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
    end
    chk("prereset_rd_addr", 32'(bus_a.rd_addr), 32'd8);
    chk("prereset_wr_data", 32'(bus_a.wr_data), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_idle_a("midreset");
    rst_n = 1'b1;
    run_a(0);

    // Odd edge N=5: only the 4x4 top-left region is read.
    kb = 0; nrd = 0; dcnt_b = 0; dcyc_b = -1; rd_seen_b = '0;
    exp_b[0] = 14'd3; exp_b[1] = 14'd5; exp_b[2] = 14'd13; exp_b[3] = 14'd15;
    unread = '{4, 9, 14, 20, 21, 22, 23, 24};
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      if (bus_b.rd_en) begin
        rd_seen_b[bus_b.rd_addr] = 1'b1;
        nrd++;
      end
      if (bus_b.wr_en) begin
        if (kb < 4) begin
          chk($sformatf("n5_wr_addr%0d", kb), 32'(bus_b.wr_addr), 32'(kb));
          chk($sformatf("n5_wr_data%0d", kb), 32'(bus_b.wr_data), 32'(exp_b[kb]));
        end
        kb++;
      end
      if (done_b) begin
        dcnt_b++;
        dcyc_b = cyc;
      end
    end
    chk("n5_writes", 32'(kb), 32'd4);
    chk("n5_reads", 32'(nrd), 32'd16);
    chk("n5_done_cnt", 32'(dcnt_b), 32'd1);
    chk("n5_done_cyc", 32'(dcyc_b), 32'd25);
    for (int i = 0; i < 8; i++)
      chk($sformatf("n5_unread_%0d", unread[i]), 32'(rd_seen_b[unread[i]]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool2x2_scheduler.md
# pool2x2_scheduler

Sequencer for the 2x2 average-pooling datapath. On a `start` pulse it walks an N×N signed 16-bit feature map held in an external single-port buffer with stride 2. For each window it fetches the four pixels, forms the pooled value through the pooling datapath, and writes the 14-bit result to an output buffer in row-major order. It sits between the conv-layer output buffer and the next layer's input buffer, and reports `busy`/`done` to the layer controller.

## Interface
- `N`, default 28: input map edge length, ≥2; output edge `M = N/2` (floor).
- `DATA_W`, default 16: input pixel width, signed.
- `OUT_W`, default 14: pooled output width.
- `clk` in, 1: clock. One clock domain; reset is synchronous and active-low.
- `rst_n` in, 1: synchronous, active-low reset.
- `start` in, 1: begin one full map pass; sampled only in IDLE.
- `busy` out, 1: high whenever state ≠ IDLE.
- `done` out, 1: one-cycle pulse when the pass completes.
- `rd_en` out, 1: input buffer read strobe.
- `rd_addr` out, `$clog2(N*N)`: input address, `row*N + col`.
- `rd_data` in, `DATA_W`: read data, valid the cycle after `rd_en`.
- `wr_en` out, 1: output write request.
- `wr_ready` in, 1: output buffer accepts the write when `wr_en & wr_ready`.
- `wr_addr` out, `$clog2(M*M)` (min 1): output address, `r*M + c`.
- `wr_data` out, `OUT_W`: pooled pixel.

## Operation
- States: IDLE, F0, F1, F2, F3, DRAIN, WRITE, DONE.
- IDLE → F0 on `start`.
- F0..F3 each issue one read, in this order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
- `rd_data` is captured into pixel registers p0..p3 the cycle after each read. p3 is captured in DRAIN.
- DRAIN → WRITE. The pooled result is registered on this transition.
- WRITE holds `wr_en`, `wr_addr` and `wr_data` stable until `wr_ready` is seen. On accept:
  - next window is c+1; at c = M-1, wrap to c = 0, r+1;
  - after window (M-1, M-1), go to DONE; otherwise go to F0.
- DONE: `done` = 1 for one cycle, then IDLE.
- Arithmetic:
  - sum = sign-extended p0+p1+p2+p3 at `DATA_W+2` bits;
  - `wr_data = sum[OUT_W+1:2]`, i.e. arithmetic shift right by 2 (floor), truncated to the low `OUT_W` bits. No saturation.
- Odd N: the last row and last column are never read.
- `start` while busy: ignored, with no effect on the counters.
- `rst_n` low at any cycle, including mid-pass: on the next edge state = IDLE and r = c = 0. The pass is abandoned; no partial `done`.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` = 0; `rd_addr`, `wr_addr`, `wr_data` = 0.
- `rd_en` is high only in F0..F3. `rd_addr` is registered with the state.
- `start` is sampled at edge 0. F0 is cycle 1.
- Window k (zero-based, no stalls) has WRITE in cycle 6k+6.
- With no stalls, `done` is in cycle 6·M²+1. Each cycle `wr_ready` is low in WRITE adds one cycle.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `wr_en` is never high in two different windows without an intervening F0..DRAIN sequence.
- Throughput: 1 output per 6 cycles, minimum.

## Structure
- Package `pool_pkg`:
  - state enum `pool_state_t`;
  - localparams `ADDR_W(N)` and `OUT_ADDR_W(N)` as functions;
  - shared `DATA_W`/`OUT_W` defaults.
- Sub-module `pool_avg_2x2`: combinational four-input signed sum with shift and truncate, width-parameterised. The scheduler instantiates it on p0..p3 and registers its output.
- The scheduler owns the FSM, the r/c counters and address generation.

## Test plan
- N=4, pixel = `row*4+col`, `wr_ready` = 1 → writes (addr, data): (0,2), (1,4), (2,10), (3,12). `done` in cycle 25.
- N=4, window (0,0) = {−3,−3,−3,−3} → `wr_data` = 0x3FFD. Window (0,1) = {−1,−1,−1,−2} → 0x3FFE (floor).
- `wr_ready` held low 3 cycles on window 1 → `wr_en`, `wr_addr` = 1 and `wr_data` = 4 held stable for 4 cycles. `done` in cycle 28.
- `start` pulsed in cycle 10 of a pass → no restart; same four writes; exactly one `done`.
- `rst_n` low in cycle 13 → next cycle all outputs 0, state IDLE. A new `start` repeats the pass from window 0.
- N=5, ramp `row*5+col` → four writes (4 reads each); addresses 4, 9, 14 and 20..24 are never read.
